// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: instruction field positions,
// type and function codes, register names and the jump-offset helper.
package instruction_fetch_unit_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned FN_W     = 5;
   localparam int unsigned TYPE_W   = 2;
   localparam int unsigned IMM_W    = 24;

   localparam int unsigned FN_MSB   = 31;
   localparam int unsigned FN_LSB   = 27;
   localparam int unsigned IMM_MSB  = 26;
   localparam int unsigned IMM_LSB  = 3;
   localparam int unsigned TYPE_MSB = 2;
   localparam int unsigned TYPE_LSB = 1;
   localparam int unsigned STOP_BIT = 0;

   typedef enum logic [TYPE_W-1:0] {
      R_TYPE = 2'b00,
      I_TYPE = 2'b01,
      J_TYPE = 2'b10,
      S_TYPE = 2'b11
   } instr_type_e;

   typedef enum logic [FN_W-1:0] {
      FN_NOP  = 5'd0,
      FN_ADD  = 5'd1,
      FN_ADDI = 5'd2,
      FN_SUB  = 5'd3,
      FN_AND  = 5'd4,
      FN_OR   = 5'd5,
      FN_LW   = 5'd6,
      FN_SW   = 5'd7,
      FN_J    = 5'd8,
      FN_JAL  = 5'd9,
      FN_JR   = 5'd10,
      FN_BEQ  = 5'd11
   } fn_e;

   typedef enum logic [4:0] {
      REG_ZERO = 5'd0,
      REG_RA   = 5'd1,
      REG_SP   = 5'd2,
      REG_GP   = 5'd3,
      REG_T0   = 5'd4,
      REG_T1   = 5'd5
   } reg_e;

   typedef struct packed {
      logic [FN_W-1:0]   fn;
      logic [IMM_W-1:0]  imm;
      logic [TYPE_W-1:0] itype;
      logic              stop;
   } instr_fields_t;

   // Signed 24-bit word offset to a 32-bit byte offset.
   function automatic logic [XLEN-1:0] jump_offset(input logic [IMM_W-1:0] imm);
      return {{6{imm[IMM_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc.sv
// Combinational next-PC selection: redirect > stall > halted > capture,
// with the early J-type jump adder inside the capture path.
module fetch_next_pc
   import instruction_fetch_unit_pkg::*;
#(
   parameter bit EARLY_JUMP = 1'b1
) (
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_instr,
   input  logic            i_stall,
   input  logic            i_halted,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_target,
   output logic [XLEN-1:0] o_next_pc_c,
   output logic            o_capture_c,
   output logic            o_halt_set_c,
   output logic            o_clear_valid_c
);

   logic [FN_W-1:0]   w_fn;
   logic [IMM_W-1:0]  w_imm;
   logic [TYPE_W-1:0] w_type;
   logic              w_stop;
   logic              w_is_jump;
   logic [XLEN-1:0]   w_target;

   assign w_fn      = i_instr[FN_MSB:FN_LSB];
   assign w_imm     = i_instr[IMM_MSB:IMM_LSB];
   assign w_type    = i_instr[TYPE_MSB:TYPE_LSB];
   assign w_stop    = i_instr[STOP_BIT];
   assign w_is_jump = EARLY_JUMP && (w_type == J_TYPE) && (w_fn == FN_J);
   assign w_target  = i_redirect_target & ~XLEN'(32'h3);

   always_comb begin
      o_next_pc_c     = i_pc;
      o_capture_c     = 1'b0;
      o_halt_set_c    = 1'b0;
      o_clear_valid_c = 1'b0;
      if (i_redirect_valid) begin
         o_next_pc_c     = w_target;
         o_clear_valid_c = 1'b1;
      end else if (i_stall) begin
         o_next_pc_c     = i_pc;
      end else if (i_halted) begin
         o_clear_valid_c = 1'b1;
      end else begin
         o_capture_c = 1'b1;
         // Stop wins over a jump encoded in the same word.
         if (w_stop) begin
            o_halt_set_c = 1'b1;
         end else if (w_is_jump) begin
            o_next_pc_c = i_pc + jump_offset(w_imm);
         end else begin
            o_next_pc_c = i_pc + XLEN'(4);
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, IF/ID pipeline register, halt flag and the
// delivered-instruction counter; next-state decisions come from fetch_next_pc.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0004,
   parameter bit          EARLY_JUMP = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] pc_out,
   input  logic [31:0] instr_in,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        halted,
   output logic [31:0] fetch_count
);

   logic [XLEN-1:0] r_pc;
   logic            r_id_valid;
   logic [XLEN-1:0] r_id_instr;
   logic [XLEN-1:0] r_id_pc;
   logic [XLEN-1:0] r_id_pc_plus4;
   logic            r_halted;
   logic [XLEN-1:0] r_fetch_count;

   logic [XLEN-1:0] w_next_pc;
   logic            w_capture;
   logic            w_halt_set;
   logic            w_clear_valid;

   fetch_next_pc #(
      .EARLY_JUMP (EARLY_JUMP)
   ) u_next_pc (
      .i_pc              (r_pc),
      .i_instr           (instr_in),
      .i_stall           (stall),
      .i_halted          (r_halted),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_target (redirect_target),
      .o_next_pc_c       (w_next_pc),
      .o_capture_c       (w_capture),
      .o_halt_set_c      (w_halt_set),
      .o_clear_valid_c   (w_clear_valid)
   );

   // PC register; holds are folded into w_next_pc.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   // IF/ID pipeline register and delivered-instruction counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_id_valid    <= 1'b0;
         r_id_instr    <= '0;
         r_id_pc       <= '0;
         r_id_pc_plus4 <= '0;
         r_fetch_count <= '0;
      end else if (w_capture) begin
         r_id_valid    <= 1'b1;
         r_id_instr    <= instr_in;
         r_id_pc       <= r_pc;
         r_id_pc_plus4 <= r_pc + XLEN'(4);
         r_fetch_count <= r_fetch_count + XLEN'(1);
      end else if (w_clear_valid) begin
         r_id_valid    <= 1'b0;
      end
   end

   // Halt flag: set by a captured stop bit, cleared only by redirect.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_halted <= 1'b0;
      end else if (redirect_valid) begin
         r_halted <= 1'b0;
      end else if (w_halt_set) begin
         r_halted <= 1'b1;
      end
   end

   assign pc_out      = r_pc;
   assign id_valid    = r_id_valid;
   assign id_instr    = r_id_instr;
   assign id_pc       = r_id_pc;
   assign id_pc_plus4 = r_id_pc_plus4;
   assign halted      = r_halted;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, early jump,
// stall/redirect, stop bit, wrap, self-loop and asynchronous reset.
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   logic        clock;
   logic        reset;
   logic [31:0] pc_out;
   logic [31:0] instr_in;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] mem [64];
   int          errors = 0;
   int          checks = 0;

   logic [31:0] w_addi1, w_addi2, w_add3, w_add4, w_jmp, w_stopw, w_self, w_stopjmp;

   instruction_fetch_unit #(
      .RESET_PC   (32'h0000_0004),
      .EARLY_JUMP (1'b1)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pc_out          (pc_out),
      .instr_in        (instr_in),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_valid        (id_valid),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .halted          (halted),
      .fetch_count     (fetch_count)
   );

   assign instr_in = mem[pc_out[7:2]];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] enc(input logic [4:0] fn, input logic [23:0] imm,
                                       input logic [1:0] t, input logic stop);
      return {fn, imm, t, stop};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic st(input string tag, input logic [31:0] pc, input logic v,
                     input logic [31:0] ipc, input logic [31:0] cnt, input logic h);
      chk({tag, ".pc"},    pc_out, pc);
      chk({tag, ".valid"}, 32'(id_valid), 32'(v));
      if (v) chk({tag, ".id_pc"}, id_pc, ipc);
      chk({tag, ".count"}, fetch_count, cnt);
      chk({tag, ".halted"}, 32'(halted), 32'(h));
   endtask

   initial begin
      w_addi1   = enc(FN_ADDI, 24'h000010, I_TYPE, 1'b0);
      w_addi2   = enc(FN_ADDI, 24'h000021, I_TYPE, 1'b0);
      w_add3    = enc(FN_ADD,  24'h000123, R_TYPE, 1'b0);
      w_add4    = enc(FN_ADD,  24'h000456, R_TYPE, 1'b0);
      w_jmp     = enc(FN_J,    24'hFFFFFE, J_TYPE, 1'b0);
      w_stopw   = enc(FN_ADD,  24'h000777, R_TYPE, 1'b1);
      w_self    = enc(FN_J,    24'h000000, J_TYPE, 1'b0);
      w_stopjmp = enc(FN_J,    24'hFFFFFF, J_TYPE, 1'b1);
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[1] = w_addi1; mem[2] = w_addi2; mem[3] = w_add3;
      mem[4] = w_add4;  mem[5] = w_jmp;   mem[16] = w_addi1; mem[63] = w_addi2;

      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      @(negedge clock);
      st("reset", 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("reset.id_instr", id_instr, 32'h0);
      reset = 1'b0;

      // Sequential fetch
      tick(); st("seq1", 32'h8, 1'b1, 32'h4, 32'd1, 1'b0);
      chk("seq1.instr", id_instr, w_addi1);
      chk("seq1.plus4", id_pc_plus4, 32'h8);
      tick(); st("seq2", 32'hC,  1'b1, 32'h8,  32'd2, 1'b0);
      tick(); st("seq3", 32'h10, 1'b1, 32'hC,  32'd3, 1'b0);
      chk("seq3.instr", id_instr, w_add3);
      tick(); st("seq4", 32'h14, 1'b1, 32'h10, 32'd4, 1'b0);

      // Early jump back by two words from 20
      tick(); st("jump", 32'hC, 1'b1, 32'h14, 32'd5, 1'b0);
      chk("jump.instr", id_instr, w_jmp);
      chk("jump.plus4", id_pc_plus4, 32'h18);
      tick(); st("postjump", 32'h10, 1'b1, 32'hC, 32'd6, 1'b0);

      // Stall for three cycles
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); st("stall", 32'h10, 1'b1, 32'hC, 32'd6, 1'b0);
         chk("stall.instr", id_instr, w_add3);
      end
      redirect_valid = 1'b1; redirect_target = 32'h0000_0043;
      tick(); st("redir", 32'h40, 1'b0, 32'h0, 32'd6, 1'b0);
      stall = 1'b0; redirect_valid = 1'b0;
      tick(); st("redir_fetch", 32'h44, 1'b1, 32'h40, 32'd7, 1'b0);

      // Stop bit at address 16
      mem[4] = w_stopw;
      redirect_valid = 1'b1; redirect_target = 32'h10;
      tick(); st("stop_redir", 32'h10, 1'b0, 32'h0, 32'd7, 1'b0);
      redirect_valid = 1'b0;
      tick(); st("stop_cap", 32'h10, 1'b1, 32'h10, 32'd8, 1'b1);
      chk("stop_cap.instr", id_instr, w_stopw);
      tick(); st("halt1", 32'h10, 1'b0, 32'h0, 32'd8, 1'b1);
      tick(); st("halt2", 32'h10, 1'b0, 32'h0, 32'd8, 1'b1);
      redirect_valid = 1'b1; redirect_target = 32'h4;
      tick(); st("resume_redir", 32'h4, 1'b0, 32'h0, 32'd8, 1'b0);
      redirect_valid = 1'b0;
      tick(); st("resume", 32'h8, 1'b1, 32'h4, 32'd9, 1'b0);

      // Wrap at the top of the address space
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick(); st("wrap_redir", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'd9, 1'b0);
      redirect_valid = 1'b0;
      tick(); st("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'd10, 1'b0);
      chk("wrap.plus4", id_pc_plus4, 32'h0);
      chk("wrap.instr", id_instr, w_addi2);
      mem[1] = w_self;
      tick(); st("null", 32'h4, 1'b1, 32'h0, 32'd11, 1'b0);

      // Self-loop jump re-fetches every cycle
      tick(); st("self1", 32'h4, 1'b1, 32'h4, 32'd12, 1'b0);
      tick(); st("self2", 32'h4, 1'b1, 32'h4, 32'd13, 1'b0);
      chk("self2.instr", id_instr, w_self);

      // Asynchronous reset between edges
      #2 reset = 1'b1;
      #1;
      st("areset", 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("areset.instr", id_instr, 32'h0);
      chk("areset.idpc", id_pc, 32'h0);
      chk("areset.plus4", id_pc_plus4, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Stop bit outranks a jump in the same word
      mem[1] = w_stopjmp;
      tick(); st("stopjmp", 32'h4, 1'b1, 32'h4, 32'd1, 1'b1);
      tick(); st("stopjmp_hold", 32'h4, 1'b0, 32'h0, 32'd1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
